key_entry: RTL



---
 rtl/mfe_pkg.sv | 18 +
 rtl/scan_to_hex.sv | 33 +++
 rtl/key_entry.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mfe_pkg.sv
// Shared constants and types for the mfe front end: PS/2 set-2 scan codes
// and the key entry state type.
package mfe_pkg;

    localparam logic [7:0] SC_MAKE  = 8'h00;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [0:0] {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } key_entry_state_t;

endpackage

// File: rtl/scan_to_hex.sv
// Combinational PS/2 set-2 scan code to hex digit decoder.
// Also used by the display echo path.
module scan_to_hex (
    input  logic [7:0] scan,
    output logic       is_hex,
    output logic [3:0] nib
);

    always_comb begin
        is_hex = 1'b1;
        nib    = 4'h0;
        case (scan)
            8'h45: nib = 4'h0;
            8'h16: nib = 4'h1;
            8'h1E: nib = 4'h2;
            8'h26: nib = 4'h3;
            8'h25: nib = 4'h4;
            8'h2E: nib = 4'h5;
            8'h36: nib = 4'h6;
            8'h3D: nib = 4'h7;
            8'h3E: nib = 4'h8;
            8'h46: nib = 4'h9;
            8'h1C: nib = 4'hA;
            8'h32: nib = 4'hB;
            8'h21: nib = 4'hC;
            8'h23: nib = 4'hD;
            8'h24: nib = 4'hE;
            8'h2B: nib = 4'hF;
            default: is_hex = 1'b0;
        endcase
    end

endmodule

// File: rtl/key_entry.sv
// Assembles typed hex digits into a KEY_BITS-wide key and hands the
// committed key to the cipher core over a valid/ready handshake.
//
//   state | meaning
//   ENTRY | collecting digits; Backspace/Esc/Enter edit or commit the buffer
//   HOLD  | key_o presented with key_valid_o high; key events ignored
module key_entry
    import mfe_pkg::*;
#(
    parameter  int KEY_BITS = 128,
    parameter  int NIBBLES  = KEY_BITS / 4,
    localparam int CW       = $clog2(NIBBLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         char_i,
    input  logic                char_valid_i,
    output logic [KEY_BITS-1:0] key_o,
    output logic                key_valid_o,
    input  logic                key_ready_i,
    output logic [CW-1:0]       nib_cnt_o,
    output logic                err_o
);

    localparam logic [CW-1:0] FULL = CW'(NIBBLES);

    key_entry_state_t    state, state_n;
    logic [KEY_BITS-1:0] key_buf, key_buf_n;
    logic [KEY_BITS-1:0] key_n;
    logic [CW-1:0]       cnt_n;
    logic                valid_n;
    logic                err_n;

    logic                make;
    logic                is_hex;
    logic [3:0]          nib;

    // Only plain make codes count; break and extended prefixes are dropped.
    assign make = char_valid_i && (char_i[15:8] == SC_MAKE);

    scan_to_hex u_scan_to_hex (
        .scan   (char_i[7:0]),
        .is_hex (is_hex),
        .nib    (nib)
    );

    always_comb begin
        state_n   = state;
        key_buf_n = key_buf;
        cnt_n     = nib_cnt_o;
        key_n     = key_o;
        valid_n   = key_valid_o;
        err_n     = 1'b0;

        case (state)
            ENTRY: begin
                if (make) begin
                    if (is_hex) begin
                        if (nib_cnt_o != FULL) begin
                            key_buf_n = {key_buf[KEY_BITS-5:0], nib};
                            cnt_n     = nib_cnt_o + CW'(1);
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        case (char_i[7:0])
                            SC_BKSP: begin
                                if (nib_cnt_o != '0) begin
                                    key_buf_n = key_buf >> 4;
                                    cnt_n     = nib_cnt_o - CW'(1);
                                end else begin
                                    err_n = 1'b1;
                                end
                            end
                            SC_ESC: begin
                                key_buf_n = '0;
                                cnt_n     = '0;
                            end
                            SC_ENTER: begin
                                if (nib_cnt_o == FULL) begin
                                    key_n     = key_buf;
                                    valid_n   = 1'b1;
                                    key_buf_n = '0;
                                    cnt_n     = '0;
                                    state_n   = HOLD;
                                end else begin
                                    err_n = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            HOLD: begin
                if (key_valid_o && key_ready_i) begin
                    valid_n = 1'b0;
                    state_n = ENTRY;
                end
            end
            default: state_n = ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ENTRY;
            key_buf     <= '0;
            nib_cnt_o   <= '0;
            key_o       <= '0;
            key_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_n;
            key_buf     <= key_buf_n;
            nib_cnt_o   <= cnt_n;
            key_o       <= key_n;
            key_valid_o <= valid_n;
            err_o       <= err_n;
        end
    end

endmodule
